// File: rtl/bcd_conv_sched_if.sv
// Requester-side bundle for the shared BCD->binary converter.
// master: the requesters (drive req/bcd_in); slave: the converter.
interface bcd_conv_sched_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned SIZE_BCD = 28,
    parameter int unsigned SIZE_BIN = 24
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*SIZE_BCD-1:0] bcd_in;
    logic [NUM_REQ-1:0]          ack;
    logic                        busy;
    logic [SIZE_BIN-1:0]         data_bin;
    logic [ID_W-1:0]             result_id;
    logic                        valid;
    logic                        err;

    modport master (
        output req, bcd_in,
        input  ack, busy, data_bin, result_id, valid, err
    );

    modport slave (
        input  req, bcd_in,
        output ack, busy, data_bin, result_id, valid, err
    );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared digit-serial BCD->binary converter with round-robin requester arbitration.
// One operand is captured per pass (IDLE -> CONV -> OUT -> IDLE); the result is
// tagged with the index of the requester that supplied it.
// Optional build macro: BCD_CHECK_EN -- flags any non-decimal digit on err.
module bcd_conv_sched #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned SIZE_BCD = 28,
    parameter int unsigned SIZE_BIN = 24
) (
    input logic             clk,
    input logic             rst,
    bcd_conv_sched_if.slave bus
);
    localparam int unsigned DIGITS = SIZE_BCD / 4;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StOut
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE_BCD-1:0] opnd_q, opnd_d;    // shifts left one digit per accumulate
    logic [SIZE_BIN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;      // last granted requester
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [SIZE_BIN-1:0] data_q, data_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                valid_q, valid_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    int unsigned         scan_idx;
    logic [3:0]          digit;

    // Current digit is always the top nibble of the shifting operand
    assign digit = opnd_q[SIZE_BCD-1 -: 4];

    // Round-robin winner: first set req scanning upward from the slot after ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!grant_found && bus.req[scan_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Next-state and datapath updates for the capture/convert/publish sequence
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        data_d  = data_q;
        id_d    = id_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    opnd_d  = bus.bcd_in[grant_idx*SIZE_BCD +: SIZE_BCD];
                    ack_d   = NUM_REQ'(1) << grant_idx;
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                // acc*10 as two shifts; overflow wraps at SIZE_BIN
                acc_d  = (acc_q << 3) + (acc_q << 1) + SIZE_BIN'(digit);
                opnd_d = opnd_q << 4;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                data_d  = acc_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset drops any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            ack_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.data_bin  = data_q;
    assign bus.result_id = id_q;
    assign bus.valid     = valid_q;

`ifdef BCD_CHECK_EN
    logic flag_q, flag_d;
    logic err_q, err_d;

    // Sticky bad-digit flag: cleared at capture, published alongside the result
    always_comb begin
        flag_d = flag_q;
        err_d  = err_q;
        if (state_q == StIdle && grant_found) begin
            flag_d = 1'b0;
        end else if (state_q == StConv && digit > 4'd9) begin
            flag_d = 1'b1;
        end
        if (state_q == StOut) begin
            err_d = flag_q;
        end
    end

    // Flag and error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            err_q  <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: stimulus pushes expected results, a monitor
// pops and compares on every valid pulse.
module tb_bcd_conv_sched;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned ID_W     = 2;
    localparam int unsigned SIZE_BCD = 28;
    localparam int unsigned SIZE_BIN = 24;
    localparam int unsigned DIGITS   = SIZE_BCD / 4;
`ifdef BCD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_conv_sched_if #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .SIZE_BCD(SIZE_BCD),
        .SIZE_BIN(SIZE_BIN)
    ) bus ();

    bcd_conv_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .SIZE_BCD(SIZE_BCD),
        .SIZE_BIN(SIZE_BIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        longint bin;
        int     id;
        int     err;
        int     cap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   model_ptr = NUM_REQ - 1;
    int   prev_cap  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint act, longint want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endfunction

    // Reference: decimal value of the digit string, MSB digit first, wrapped to SIZE_BIN
    function automatic longint ref_bin(logic [SIZE_BCD-1:0] op);
        longint v = 0;
        for (int k = 0; k < DIGITS; k++) v = v * 10 + longint'(op[SIZE_BCD-1-4*k -: 4]);
        return v % (longint'(1) << SIZE_BIN);
    endfunction

    function automatic int ref_err(logic [SIZE_BCD-1:0] op);
        bit bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) if (op[4*k +: 4] > 4'd9) bad = 1'b1;
        return (bad && CHECK_EN) ? 1 : 0;
    endfunction

    function automatic int rr_pick(logic [NUM_REQ-1:0] r, int p);
        for (int i = 1; i <= NUM_REQ; i++) if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [SIZE_BCD-1:0] rand_op();
        logic [SIZE_BCD-1:0] v;
        for (int k = 0; k < DIGITS; k++)
            v[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic set_op(input int i, input logic [SIZE_BCD-1:0] v);
        bus.bcd_in[i*SIZE_BCD +: SIZE_BCD] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next ack and check it against the model's round-robin winner
    task automatic serve(input bit gap_chk, output int w);
        int waited = 0;
        logic [SIZE_BCD-1:0] op;
        w = rr_pick(bus.req, model_ptr);
        do begin
            tick();
            waited++;
        end while (bus.ack == '0 && waited < 40);
        if (bus.ack == '0) begin
            n_checks++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected ack for req %0d",
                     waited, w);
            w = -1;
            return;
        end
        check("ack_grant", bus.ack, (w >= 0) ? (1 << w) : 0);
        if (w < 0) return;
        op = bus.bcd_in[w*SIZE_BCD +: SIZE_BCD];
        exp_q.push_back('{bin: ref_bin(op), id: w, err: ref_err(op), cap: cyc});
        if (gap_chk && prev_cap >= 0) check("capture_gap", cyc - prev_cap, DIGITS + 2);
        prev_cap  = cyc;
        model_ptr = w;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
        prev_cap = -1;
    endtask

    // Simple single-requester transaction
    task automatic single(input int i, input logic [SIZE_BCD-1:0] v);
        int w;
        set_op(i, v);
        bus.req = NUM_REQ'(1) << i;
        serve(1'b0, w);
        bus.req = '0;
        drain();
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            tick();
            if (!rst && bus.valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: id=%0d data=%0d, expected no result",
                             bus.result_id, bus.data_bin);
                end else begin
                    e = exp_q.pop_front();
                    check("data_bin", bus.data_bin, e.bin);
                    check("result_id", bus.result_id, e.id);
                    check("err", bus.err, e.err);
                    check("latency", cyc - e.cap, DIGITS + 1);
                end
            end
        end
    end

    initial begin
        int w;
        int order [5] = '{0, 1, 2, 3, 0};
        int ack1_seen;

        rst        = 1'b1;
        bus.req    = '0;
        bus.bcd_in = '0;
        repeat (2) tick();
        check("rst_ack", bus.ack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_data", bus.data_bin, 0);
        check("rst_id", bus.result_id, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic conversion, boundaries and digit-check cases
        single(0, 28'h1234567);
        single(1, 28'h9999999);
        single(2, 28'h0000000);
        single(3, 28'h00000A0);
        single(3, 28'h0000010);

        // All four held high: strict rotation, one capture per DIGITS+2 cycles
        for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_op());
        bus.req = '1;
        for (int n = 0; n < 5; n++) begin
            serve(1'b1, w);
            check("rr_order", w, order[n]);
            if (w >= 0) set_op(w, rand_op());
        end
        bus.req = '0;
        drain();

        // Random request patterns with re-requests
        bus.req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_op());
        for (int n = 0; n < 40; n++) begin
            serve(1'b1, w);
            if (w < 0) break;
            bus.req[w] = 1'($urandom_range(0, 1));
            set_op(w, rand_op());
            for (int i = 0; i < NUM_REQ; i++)
                if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    set_op(i, rand_op());
                    bus.req[i] = 1'b1;
                end
            if (bus.req == '0) bus.req[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
        end
        bus.req = '0;
        drain();

        // req[1] pulsed during CONV and withdrawn: never served
        set_op(0, rand_op());
        bus.req = 4'b0001;
        serve(1'b0, w);
        bus.req = '0;
        repeat (2) tick();
        set_op(1, rand_op());
        bus.req[1] = 1'b1;
        tick();
        bus.req[1] = 1'b0;
        ack1_seen = 0;
        repeat (14) begin
            tick();
            if (bus.ack[1]) ack1_seen++;
        end
        check("dropped_req_acks", ack1_seen, 0);
        drain();

        // Reset mid-conversion: no result, outputs cleared, pointer restarts
        set_op(0, 28'h7654321);
        bus.req = 4'b0001;
        serve(1'b0, w);
        bus.req = '0;
        repeat (3) tick();
        check("busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        #1;
        check("midrst_ack", bus.ack, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.valid, 0);
        check("midrst_data", bus.data_bin, 0);
        check("midrst_id", bus.result_id, 0);
        check("midrst_err", bus.err, 0);
        tick();
        rst       = 1'b0;
        model_ptr = NUM_REQ - 1;
        prev_cap  = -1;
        repeat (12) tick();
        check("post_rst_busy", bus.busy, 0);
        single(2, 28'h0031415);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
